// File: rtl/btn_debounce_sync.sv
// btn_debounce_sync
// Turns a raw, bouncing push-button level into a clean synchronous level.
// The path is a 2-flop synchronizer, then a consecutive-sample debounce FSM.
// The FSM also produces one-cycle rise/fall pulses and a saturating count
// of pending transitions that were aborted (glitches).
// State is {D_out, pending}, where pending means the debounce counter is nonzero.
module btn_debounce_sync #(
  parameter int  STABLE_CYCLES = 4,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Btn_in,
  output logic       D_out,
  output logic       Rise_pulse,
  output logic       Fall_pulse,
  output logic [7:0] Glitch_cnt
);

  // Counter value at which the next differing sample commits the flip.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit 1 mirrors D_out; bit 0 is set while a transition is pending.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    PEND_LOW    = 2'b11
  } state_t;

  logic             s1_reg;
  logic             s2_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             d_out_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic [7:0]       glitch_reg;

  // Two-flop synchronizer. Only s2_reg feeds the debounce logic.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= Btn_in;
      s2_reg <= s1_reg;
    end
  end

  // Debounce FSM: count consecutive differing samples, commit or abort.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg  <= STABLE_LOW;
      cnt_reg    <= '0;
      d_out_reg  <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      glitch_reg <= 8'd0;
    end else begin
      // Pulses last exactly one cycle unless a flip re-asserts them below.
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      case (state_reg)
        STABLE_LOW: begin
          if (s2_reg) begin
            if (cnt_reg == CNT_LAST) begin
              // A single required sample flips immediately.
              state_reg <= STABLE_HIGH;
              d_out_reg <= 1'b1;
              rise_reg  <= 1'b1;
              cnt_reg   <= '0;
            end else begin
              state_reg <= PEND_HIGH;
              cnt_reg   <= cnt_reg + CNT_ONE;
            end
          end
        end
        PEND_HIGH: begin
          if (!s2_reg) begin
            // The input fell back before it was stable long enough.
            state_reg <= STABLE_LOW;
            cnt_reg   <= '0;
            if (glitch_reg != 8'hFF) glitch_reg <= glitch_reg + 8'd1;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= STABLE_HIGH;
            d_out_reg <= 1'b1;
            rise_reg  <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s2_reg) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= STABLE_LOW;
              d_out_reg <= 1'b0;
              fall_reg  <= 1'b1;
              cnt_reg   <= '0;
            end else begin
              state_reg <= PEND_LOW;
              cnt_reg   <= cnt_reg + CNT_ONE;
            end
          end
        end
        PEND_LOW: begin
          if (s2_reg) begin
            state_reg <= STABLE_HIGH;
            cnt_reg   <= '0;
            if (glitch_reg != 8'hFF) glitch_reg <= glitch_reg + 8'd1;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= STABLE_LOW;
            d_out_reg <= 1'b0;
            fall_reg  <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= STABLE_LOW;
          cnt_reg   <= '0;
          d_out_reg <= 1'b0;
        end
      endcase
    end
  end

  assign D_out      = d_out_reg;
  assign Rise_pulse = rise_reg;
  assign Fall_pulse = fall_reg;
  assign Glitch_cnt = glitch_reg;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Bench for btn_debounce_sync: one instance with STABLE_CYCLES=4 and one with
// STABLE_CYCLES=1, both driven by the same button and reset. A run-length model
// predicts every output after every clock edge. Literal checks pin the key timings.
module tb_btn_debounce_sync;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Btn_in = 1'b0;
  logic       d4, r4, f4, d1, r1, f1;
  logic [7:0] g4, g1;

  always #5 Clk = ~Clk;

  btn_debounce_sync #(.STABLE_CYCLES(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Btn_in(Btn_in),
    .D_out(d4), .Rise_pulse(r4), .Fall_pulse(f4), .Glitch_cnt(g4)
  );

  btn_debounce_sync #(.STABLE_CYCLES(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Btn_in(Btn_in),
    .D_out(d1), .Rise_pulse(r1), .Fall_pulse(f1), .Glitch_cnt(g1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state, index 0 = STABLE_CYCLES 4, index 1 = STABLE_CYCLES 1.
  int sc[2] = '{4, 1};
  int hist[2][2];        // button samples from the last two edges (sync delay)
  int run[2];            // consecutive samples differing from the output level
  int m_d[2], m_rise[2], m_fall[2], m_glitch[2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      hist[i][0] = 0; hist[i][1] = 0; run[i] = 0;
      m_d[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_glitch[i] = 0;
    end
  endtask

  // The debounce logic sees the button value sampled two edges earlier.
  task automatic model_edge();
    int v;
    for (int i = 0; i < 2; i++) begin
      v = hist[i][1];
      hist[i][1] = hist[i][0];
      hist[i][0] = int'(Btn_in);
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (v == m_d[i]) begin
        if (run[i] > 0) m_glitch[i] = (m_glitch[i] >= 255) ? 255 : m_glitch[i] + 1;
        run[i] = 0;
      end else begin
        run[i] = run[i] + 1;
        if (run[i] == sc[i]) begin
          m_d[i] = v;
          m_rise[i] = v;
          m_fall[i] = 1 - v;
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("sc4 d_out", int'(d4), m_d[0]);
    chk("sc4 rise", int'(r4), m_rise[0]);
    chk("sc4 fall", int'(f4), m_fall[0]);
    chk("sc4 glitch", int'(g4), m_glitch[0]);
    chk("sc1 d_out", int'(d1), m_d[1]);
    chk("sc1 rise", int'(r1), m_rise[1]);
    chk("sc1 fall", int'(f1), m_fall[1]);
    chk("sc1 glitch", int'(g1), m_glitch[1]);
  endtask

  // Apply one button level across one clock edge, then compare with the model.
  task automatic step(input logic b);
    Btn_in = b;
    @(posedge Clk);
    #1;
    if (Rst) model_clear();
    else model_edge();
    check_model();
    $display("t=%0t rst=%0d btn=%0d | sc4 d=%0d r=%0d f=%0d g=%0d | sc1 d=%0d r=%0d f=%0d g=%0d",
             $time, Rst, b, d4, r4, f4, g4, d1, r1, f1, g1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " d_out"}, int'(d4), 0);
    chk({tag, " rise"}, int'(r4), 0);
    chk({tag, " fall"}, int'(f4), 0);
    chk({tag, " glitch"}, int'(g4), 0);
    chk({tag, " sc1 d_out"}, int'(d1), 0);
    chk({tag, " sc1 glitch"}, int'(g1), 0);
  endtask

  // Raise reset between edges, confirm outputs clear without a clock, release at negedge.
  task automatic do_reset(input string tag);
    #3;
    Rst = 1'b1;
    #1;
    check_all_zero(tag);
    model_clear();
    step(Btn_in);
    chk({tag, " no fall in reset"}, int'(f4), 0);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    Rst = 1'b1;
    #1;
    check_all_zero("reset");
    step(1'b0);
    @(negedge Clk);
    Rst = 1'b0;

    // Clean press: 10 low, then 12 high; E0 is the first high step.
    repeat (10) step(1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1);
      chk("press d_out", int'(d4), (k >= 5) ? 1 : 0);
      chk("press rise", int'(r4), (k == 5) ? 1 : 0);
    end
    chk("press glitch", int'(g4), 0);

    // Release from stable high.
    for (int k = 0; k < 10; k++) begin
      step(1'b0);
      chk("release d_out", int'(d4), (k < 5) ? 1 : 0);
      chk("release fall", int'(f4), (k == 5) ? 1 : 0);
      chk("release rise", int'(r4), 0);
    end

    // Bounce: 1 x3, 0 x2, 1 x2, then low; two aborted pendings.
    repeat (3) step(1'b1);
    repeat (2) step(1'b0);
    repeat (2) step(1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      chk("bounce d_out", int'(d4), 0);
      chk("bounce rise", int'(r4), 0);
    end
    chk("bounce glitch", int'(g4), 2);

    // Saturation: 300 one-cycle pulses, 3 cycles apart.
    for (int p = 0; p < 300; p++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
    chk("sat glitch", int'(g4), 255);
    chk("sat d_out", int'(d4), 0);
    repeat (2) begin
      step(1'b1); step(1'b0); step(1'b0);
    end
    chk("sat hold glitch", int'(g4), 255);

    // Async reset while a low transition is pending from D_out=1.
    do_reset("clear");
    repeat (8) step(1'b1);
    chk("pre-reset high", int'(d4), 1);
    repeat (4) step(1'b0);
    chk("pending still high", int'(d4), 1);
    Btn_in = 1'b1;
    do_reset("mid-pend");
    for (int k = 0; k < 8; k++) begin
      step(1'b1);
      chk("after rst d_out", int'(d4), (k >= 5) ? 1 : 0);
      chk("after rst rise", int'(r4), (k == 5) ? 1 : 0);
      chk("after rst fall", int'(f4), 0);
    end

    // STABLE_CYCLES=1: a single-cycle high pulse flips 2 edges after E0.
    Btn_in = 1'b0;
    do_reset("sc1");
    repeat (3) step(1'b0);
    for (int k = 0; k < 6; k++) begin
      step((k == 0) ? 1'b1 : 1'b0);
      chk("sc1 pulse d_out", int'(d1), (k == 2) ? 1 : 0);
      chk("sc1 pulse rise", int'(r1), (k == 2) ? 1 : 0);
      chk("sc1 pulse fall", int'(f1), (k == 3) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
